// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - fixed-priority arbiter sharing one RAM port between instruction fetch and MEM stage
// MEM wins over IF; an access ends on ram_ready or after TIMEOUT wait cycles with bus_err.
module bus_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        bus_err,
  output logic        stall_req
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY_IF  = 2'd1;
  localparam logic [1:0] S_BUSY_MEM = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_sel;
  logic          r_we;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_mem_rdata;
  logic          r_if_ack;
  logic          r_mem_ack;
  logic          r_bus_err;

  logic w_busy;
  logic w_done;
  logic w_timeout;
  logic w_grant_mem;
  logic w_grant_if;

  assign w_busy    = (r_state == S_BUSY_IF) | (r_state == S_BUSY_MEM);
  assign w_done    = w_busy & ram_ready;
  assign w_timeout = w_busy & ~ram_ready & (r_cnt == CW'(TIMEOUT - 1));

  // During the ack cycle the just-served requester still holds req; mask it out.
  assign w_grant_mem = (r_state == S_IDLE) & mem_req & ~r_mem_ack;
  assign w_grant_if  = (r_state == S_IDLE) & ~w_grant_mem & if_req & ~r_if_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      r_bus_err <= 1'b0;
      if (w_grant_mem) begin
        r_state <= S_BUSY_MEM;
        r_cnt   <= '0;
        r_addr  <= mem_addr;
        r_we    <= mem_we;
        r_wdata <= mem_wdata;
        r_sel   <= mem_sel;
      end else if (w_grant_if) begin
        r_state <= S_BUSY_IF;
        r_cnt   <= '0;
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_sel   <= 4'hF;
      end else if (w_done | w_timeout) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_bus_err <= w_timeout;
        if (r_state == S_BUSY_MEM) begin
          r_mem_ack   <= 1'b1;
          r_mem_rdata <= w_done ? ram_rdata : 32'h0;
        end else begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= w_done ? ram_rdata : 32'h0;
        end
      end else if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign ram_ce    = w_busy;
  assign ram_we    = w_busy & r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_sel   = r_sel;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_ack    = r_if_ack;
  assign mem_ack   = r_mem_ack;
  assign bus_err   = r_bus_err;
  assign stall_req = (if_req & ~r_if_ack) | (mem_req & ~r_mem_ack);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - table-driven bench for bus_arbiter plus hand-written corner sequences
module tb_bus_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;
  logic        bus_err;
  logic        stall_req;

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_sel(ram_sel), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .bus_err(bus_err), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] rdata;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [6];
  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] m_if_rdata  = '0;
  logic [31:0] m_mem_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata; mem_sel = v.sel;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1 chk($sformatf("v%0d stall_on", idx), 32'(stall_req), 32'd1);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      ram_ready = 1'b0;
      if (if_ack | mem_ack) begin
        got = 1'b1;
        lat = k;
      end else if (ram_ce) begin
        if (k == 1) begin
          chk($sformatf("v%0d ram_addr", idx), ram_addr, v.addr);
          chk($sformatf("v%0d ram_we", idx), 32'(ram_we), 32'(v.exp_we));
          chk($sformatf("v%0d ram_sel", idx), 32'(ram_sel), 32'(v.exp_sel));
          chk($sformatf("v%0d ram_wdata", idx), ram_wdata, v.exp_wdata);
        end
        if (k - 1 == v.delay) begin
          ram_ready = 1'b1;
          ram_rdata = v.rdata;
        end
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(v.exp_err));
    chk($sformatf("v%0d ram_ce_in_ack", idx), 32'(ram_ce), 32'd0);
    if (v.is_mem) begin
      chk($sformatf("v%0d acks", idx), {30'd0, if_ack, mem_ack}, 32'd1);
      chk($sformatf("v%0d mem_rdata", idx), mem_rdata, v.exp_rdata);
      chk($sformatf("v%0d if_rdata_hold", idx), if_rdata, m_if_rdata);
      m_mem_rdata = v.exp_rdata;
    end else begin
      chk($sformatf("v%0d acks", idx), {30'd0, if_ack, mem_ack}, 32'd2);
      chk($sformatf("v%0d if_rdata", idx), if_rdata, v.exp_rdata);
      chk($sformatf("v%0d mem_rdata_hold", idx), mem_rdata, m_mem_rdata);
      m_if_rdata = v.exp_rdata;
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    #1 chk($sformatf("v%0d stall_off", idx), 32'(stall_req), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d ack_one_cycle", idx), {29'd0, if_ack, mem_ack, bus_err}, 32'd0);
    chk($sformatf("v%0d idle_addr_hold", idx), ram_addr, v.addr);
    chk($sformatf("v%0d idle_ce_we", idx), {30'd0, ram_ce, ram_we}, 32'd0);
  endtask

  initial begin
    int pulses;
    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,         4'h0,    0,  32'h3401_0020, 2,  1'b0, 32'h3401_0020, 1'b0, 4'hF,    32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h2000, 32'hDEADBEEF,  4'b0011, 2,  32'h1111_1111, 4,  1'b0, 32'h1111_1111, 1'b1, 4'b0011, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h44,   32'h5555_5555, 4'hF,    99, 32'hFFFF_FFFF, 16, 1'b1, 32'h0,         1'b0, 4'hF,    32'h5555_5555};
    vecs[3] = '{1'b0, 1'b0, 32'h200,  32'h0,         4'h0,    14, 32'hCAFE_0001, 16, 1'b0, 32'hCAFE_0001, 1'b0, 4'hF,    32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h204,  32'h0,         4'h0,    99, 32'h1234_5678, 16, 1'b1, 32'h0,         1'b0, 4'hF,    32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h48,   32'h0,         4'b1100, 1,  32'hA5A5_0F0F, 3,  1'b0, 32'hA5A5_0F0F, 1'b0, 4'b1100, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ce_we", {30'd0, ram_ce, ram_we}, 32'd0);
    chk("rst ram_addr", ram_addr, 32'h0);
    chk("rst ram_wdata", ram_wdata, 32'h0);
    chk("rst ram_sel", 32'(ram_sel), 32'h0);
    chk("rst ack_err", {29'd0, if_ack, mem_ack, bus_err}, 32'd0);
    chk("rst rdata", if_rdata | mem_rdata, 32'h0);
    rst = 1'b0;

    // ram_ready with no request must not start or finish anything
    ram_ready = 1'b1;
    ram_rdata = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    chk("idle_ready ce", 32'(ram_ce), 32'd0);
    chk("idle_ready acks", {29'd0, if_ack, mem_ack, bus_err}, 32'd0);
    chk("idle_ready rdata", if_rdata | mem_rdata, 32'h0);
    ram_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

    // Simultaneous requests: MEM first, then IF
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_sel = 4'b0011;
    #1 chk("both stall0", 32'(stall_req), 32'd1);
    @(negedge clk);
    chk("both mem_grant", {ram_ce, ram_we, ram_sel}, {1'b1, 1'b1, 4'b0011});
    chk("both mem_addr", ram_addr, 32'h2000);
    chk("both stall1", 32'(stall_req), 32'd1);
    ram_ready = 1'b1; ram_rdata = 32'h0000_0042;
    @(negedge clk);
    ram_ready = 1'b0;
    chk("both mem_ack", {30'd0, if_ack, mem_ack}, 32'd1);
    chk("both stall2", 32'(stall_req), 32'd1);
    mem_req = 1'b0;
    @(negedge clk);
    chk("both if_grant", {ram_ce, ram_we, ram_sel}, {1'b1, 1'b0, 4'hF});
    chk("both if_addr", ram_addr, 32'h300);
    chk("both stall3", 32'(stall_req), 32'd1);
    ram_ready = 1'b1; ram_rdata = 32'h0000_ABCD;
    @(negedge clk);
    ram_ready = 1'b0;
    chk("both if_ack", {30'd0, if_ack, mem_ack}, 32'd2);
    chk("both if_rdata", if_rdata, 32'h0000_ABCD);
    chk("both mem_rdata", mem_rdata, 32'h0000_0042);
    chk("both stall4", 32'(stall_req), 32'd0);
    m_if_rdata = 32'h0000_ABCD;
    m_mem_rdata = 32'h0000_0042;
    if_req = 1'b0;
    mem_we = 1'b0;

    // Owner drops req right after the grant; access still completes once
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk);
    chk("drop granted", 32'(ram_ce), 32'd1);
    if_req = 1'b0;
    #1 chk("drop stall", 32'(stall_req), 32'd0);
    pulses = 0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      ram_ready = 1'b0;
      if (if_ack) pulses++;
      if (ram_ce && k == 4) begin
        ram_ready = 1'b1;
        ram_rdata = 32'h0000_BEEF;
      end
    end
    chk("drop pulses", 32'(pulses), 32'd1);
    chk("drop if_rdata", if_rdata, 32'h0000_BEEF);

    // Asynchronous reset during BUSY_MEM, then re-arbitration of the held request
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5A0; mem_sel = 4'hF;
    @(negedge clk);
    chk("arst busy", 32'(ram_ce), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst ce", {30'd0, ram_ce, mem_ack}, 32'd0);
    chk("arst addr", ram_addr, 32'h0);
    chk("arst rdata", if_rdata | mem_rdata, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arst regrant", {30'd0, ram_ce, mem_ack}, 32'd2);
    chk("arst regrant_addr", ram_addr, 32'h5A0);
    ram_ready = 1'b1; ram_rdata = 32'h0000_0077;
    @(negedge clk);
    ram_ready = 1'b0;
    chk("arst ack", {30'd0, if_ack, mem_ack}, 32'd1);
    chk("arst mem_rdata", mem_rdata, 32'h0000_0077);
    mem_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
